mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Responder for the pipelined core's split instruction (a) and data (b) memory ports. Serializes both ports onto a single physical memory port (pmem) and returns completion to the core. Sits between the datapath and the cache/physical memory.

Parameters:
WIDTH, 16, data/address word width (lc3b_word)
PRIORITY_B, 1, 1 = port b wins simultaneous eligibility; 0 = port a wins

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
mem_read_a  input  1  port a read request
mem_write_a  input  1  port a write request
mem_wmask_a  input  2  port a byte write mask
mem_address_a  input  WIDTH  port a address
mem_wdata_a  input  WIDTH  port a write data
mem_resp_a  output  1  port a completion
mem_rdata_a  output  WIDTH  port a read data (registered)
mem_read_b  input  1  port b read request
mem_write_b  input  1  port b write request
mem_wmask_b  input  2  port b byte write mask
mem_address_b  input  WIDTH  port b address
mem_wdata_b  input  WIDTH  port b write data
mem_resp_b  output  1  port b completion
mem_rdata_b  output  WIDTH  port b read data (registered)
pmem_read  output  1  physical read strobe
pmem_write  output  1  physical write strobe
pmem_wmask  output  2  physical byte mask
pmem_address  output  WIDTH  physical address
pmem_wdata  output  WIDTH  physical write data
pmem_resp  input  1  physical completion
pmem_rdata  input  WIDTH  physical read data

Behaviour:
- Reset (async, reset_n=0): state IDLE; done_a=done_b=0; mem_rdata_a/b=0; all pmem_* outputs 0; mem_resp_a/b=0.
- req_x = mem_read_x | mem_write_x; read wins if both asserted (write dropped). elig_x = req_x & !done_x.
- IDLE: elig_b & (PRIORITY_B | !elig_a) -> BUSY_B; else elig_a -> BUSY_A; else stay. On grant, latch op, address, wdata, wmask of the granted port.
- BUSY_x: pmem_read/pmem_write driven from latched op; pmem_address/wdata/wmask from latched values; requester changes ignored. Stay until pmem_resp=1; then capture pmem_rdata into mem_rdata_x (reads only; writes leave mem_rdata_x unchanged), set done_x, -> IDLE. pmem_* outputs 0 in IDLE.
- pmem_resp while IDLE is ignored.
- Minimum latency: request seen at edge N -> BUSY at N+1 -> pmem_resp in that cycle -> done_x/mem_resp_x at N+2.
- Release: when no port is eligible and done_a|done_b, both done flags clear at next edge. A port thus cannot be re-served until the other port's active request has completed (no starvation under held requests).
- Reset mid-transaction: outstanding pmem access abandoned, no response generated.

Optional Feature:
RESP_HOLD_EN defined: mem_resp_x = done_x; completion held until release, so both responses are simultaneously high in the release cycle (required by the core, which advances only when both ports respond). Undefined: mem_resp_x is a single-cycle pulse on the cycle after pmem_resp; done flags and release logic unchanged.

Test Plan:
- Reset with pmem_resp=1, all requests high -> all outputs 0, state IDLE until reset_n rises.
- Port a read 0x0040 only, pmem_rdata=0x1234 with 2-cycle pmem latency -> pmem_read=1 addr 0x0040 two cycles; mem_rdata_a=0x1234, mem_resp_a=1 next cycle.
- Simultaneous a read 0x0010 and b write 0x0200 data 0xBEEF mask 2'b01, PRIORITY_B=1 -> pmem write 0x0200 first, then read 0x0010; with RESP_HOLD_EN mem_resp_a & mem_resp_b both high for one cycle, then flags cleared.
- Held b request after done_b with a pending -> a served next, b not re-served before release.
- reset_n pulsed low in BUSY_A -> pmem_read drops asynchronously, no mem_resp_a; later pmem_resp ignored.
- Without RESP_HOLD_EN, b read 0x0100 -> mem_resp_b high exactly one cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the core's split a/b memory ports and the shared physical port.
// slave = arbiter view; master = core plus physical memory view.
interface mem_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             mem_read_a;
    logic             mem_write_a;
    logic [1:0]       mem_wmask_a;
    logic [WIDTH-1:0] mem_address_a;
    logic [WIDTH-1:0] mem_wdata_a;
    logic             mem_resp_a;
    logic [WIDTH-1:0] mem_rdata_a;

    logic             mem_read_b;
    logic             mem_write_b;
    logic [1:0]       mem_wmask_b;
    logic [WIDTH-1:0] mem_address_b;
    logic [WIDTH-1:0] mem_wdata_b;
    logic             mem_resp_b;
    logic [WIDTH-1:0] mem_rdata_b;

    logic             pmem_read;
    logic             pmem_write;
    logic [1:0]       pmem_wmask;
    logic [WIDTH-1:0] pmem_address;
    logic [WIDTH-1:0] pmem_wdata;
    logic             pmem_resp;
    logic [WIDTH-1:0] pmem_rdata;

    modport slave (
        input  mem_read_a, mem_write_a, mem_wmask_a,
        input  mem_address_a, mem_wdata_a,
        output mem_resp_a, mem_rdata_a,
        input  mem_read_b, mem_write_b, mem_wmask_b,
        input  mem_address_b, mem_wdata_b,
        output mem_resp_b, mem_rdata_b,
        output pmem_read, pmem_write, pmem_wmask,
        output pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport master (
        output mem_read_a, mem_write_a, mem_wmask_a,
        output mem_address_a, mem_wdata_a,
        input  mem_resp_a, mem_rdata_a,
        output mem_read_b, mem_write_b, mem_wmask_b,
        output mem_address_b, mem_wdata_b,
        input  mem_resp_b, mem_rdata_b,
        input  pmem_read, pmem_write, pmem_wmask,
        input  pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serializes core ports a and b onto one physical memory port.
// RESP_HOLD_EN: hold mem_resp_x high until both ports are released.
module mem_arbiter #(
    parameter int WIDTH      = 16,
    parameter bit PRIORITY_B = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY_A,
        BUSY_B
    } state_t;

    state_t           state, state_n;
    logic             done_a, done_b;
    logic             done_a_n, done_b_n;
    logic             lat_read, lat_write;
    logic [1:0]       lat_wmask;
    logic [WIDTH-1:0] lat_addr, lat_wdata;
    logic [WIDTH-1:0] rdata_a, rdata_b;

    logic elig_a, elig_b;
    logic grant_a, grant_b;
    logic rel;
    logic busy;

    assign elig_a  = (bus.mem_read_a | bus.mem_write_a) & ~done_a;
    assign elig_b  = (bus.mem_read_b | bus.mem_write_b) & ~done_b;
    assign grant_b = elig_b & (PRIORITY_B | ~elig_a);
    assign grant_a = elig_a & ~grant_b;
    assign rel     = ~elig_a & ~elig_b & (done_a | done_b);
    assign busy    = (state != IDLE);

    always_comb begin
        state_n  = state;
        done_a_n = done_a;
        done_b_n = done_b;
        unique case (state)
            IDLE: begin
                if (grant_b)
                    state_n = BUSY_B;
                else if (grant_a)
                    state_n = BUSY_A;
                if (rel) begin
                    done_a_n = 1'b0;
                    done_b_n = 1'b0;
                end
            end
            BUSY_A: begin
                if (bus.pmem_resp) begin
                    done_a_n = 1'b1;
                    state_n  = IDLE;
                end
            end
            BUSY_B: begin
                if (bus.pmem_resp) begin
                    done_b_n = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            done_a    <= 1'b0;
            done_b    <= 1'b0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            lat_wmask <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_a   <= '0;
            rdata_b   <= '0;
        end else begin
            state  <= state_n;
            done_a <= done_a_n;
            done_b <= done_b_n;
            // Read wins when a port raises both strobes
            if (state == IDLE && grant_b) begin
                lat_read  <= bus.mem_read_b;
                lat_write <= bus.mem_write_b & ~bus.mem_read_b;
                lat_wmask <= bus.mem_wmask_b;
                lat_addr  <= bus.mem_address_b;
                lat_wdata <= bus.mem_wdata_b;
            end else if (state == IDLE && grant_a) begin
                lat_read  <= bus.mem_read_a;
                lat_write <= bus.mem_write_a & ~bus.mem_read_a;
                lat_wmask <= bus.mem_wmask_a;
                lat_addr  <= bus.mem_address_a;
                lat_wdata <= bus.mem_wdata_a;
            end
            if (bus.pmem_resp && lat_read) begin
                if (state == BUSY_A)
                    rdata_a <= bus.pmem_rdata;
                if (state == BUSY_B)
                    rdata_b <= bus.pmem_rdata;
            end
        end
    end

    assign bus.pmem_read    = busy & lat_read;
    assign bus.pmem_write   = busy & lat_write;
    assign bus.pmem_wmask   = busy ? lat_wmask : 2'b00;
    assign bus.pmem_address = busy ? lat_addr : '0;
    assign bus.pmem_wdata   = busy ? lat_wdata : '0;
    assign bus.mem_rdata_a  = rdata_a;
    assign bus.mem_rdata_b  = rdata_b;

`ifdef RESP_HOLD_EN
    assign bus.mem_resp_a = done_a;
    assign bus.mem_resp_b = done_b;
`else
    logic resp_a_q, resp_b_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_a_q <= 1'b0;
            resp_b_q <= 1'b0;
        end else begin
            resp_a_q <= (state == BUSY_A) & bus.pmem_resp;
            resp_b_q <= (state == BUSY_B) & bus.pmem_resp;
        end
    end

    assign bus.mem_resp_a = resp_a_q;
    assign bus.mem_resp_b = resp_b_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; honours RESP_HOLD_EN when defined.
// Inputs change 1ns after the rising edge, outputs are checked there too.
module tb_mem_arbiter;
    localparam int WIDTH = 16;
`ifdef RESP_HOLD_EN
    localparam logic [15:0] HOLD = 16'd1;
`else
    localparam logic [15:0] HOLD = 16'd0;
`endif

    logic clk;
    logic reset_n;
    int   tests;
    int   failed;

    mem_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mem_arbiter #(
        .WIDTH(WIDTH),
        .PRIORITY_B(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_read_a    = 1'b0;
        bus.mem_write_a   = 1'b0;
        bus.mem_wmask_a   = 2'b00;
        bus.mem_address_a = '0;
        bus.mem_wdata_a   = '0;
        bus.mem_read_b    = 1'b0;
        bus.mem_write_b   = 1'b0;
        bus.mem_wmask_b   = 2'b00;
        bus.mem_address_b = '0;
        bus.mem_wdata_b   = '0;
        bus.pmem_resp     = 1'b0;
        bus.pmem_rdata    = '0;
    endtask

    task automatic chk_pmem_idle(input string tag);
        chk({tag, "_prd"}, {15'd0, bus.pmem_read}, 16'd0);
        chk({tag, "_pwr"}, {15'd0, bus.pmem_write}, 16'd0);
        chk({tag, "_paddr"}, bus.pmem_address, 16'h0000);
    endtask

    initial begin
        tests  = 0;
        failed = 0;

        // Reset with everything active
        reset_n           = 1'b0;
        bus.mem_read_a    = 1'b1;
        bus.mem_write_a   = 1'b1;
        bus.mem_wmask_a   = 2'b11;
        bus.mem_address_a = 16'hFFFF;
        bus.mem_wdata_a   = 16'hFFFF;
        bus.mem_read_b    = 1'b1;
        bus.mem_write_b   = 1'b1;
        bus.mem_wmask_b   = 2'b11;
        bus.mem_address_b = 16'hFFFF;
        bus.mem_wdata_b   = 16'hFFFF;
        bus.pmem_resp     = 1'b1;
        bus.pmem_rdata    = 16'hFFFF;
        step();
        step();
        step();
        chk_pmem_idle("rst");
        chk("rst_pmask", {14'd0, bus.pmem_wmask}, 16'd0);
        chk("rst_pwdata", bus.pmem_wdata, 16'h0000);
        chk("rst_resp_a", {15'd0, bus.mem_resp_a}, 16'd0);
        chk("rst_resp_b", {15'd0, bus.mem_resp_b}, 16'd0);
        chk("rst_rdata_a", bus.mem_rdata_a, 16'h0000);
        chk("rst_rdata_b", bus.mem_rdata_b, 16'h0000);
        idle_inputs();
        reset_n = 1'b1;
        step();
        chk_pmem_idle("post_rst");

        // Port a read, two-cycle pmem latency
        bus.mem_read_a    = 1'b1;
        bus.mem_address_a = 16'h0040;
        step();
        chk("a_rd_c1", {15'd0, bus.pmem_read}, 16'd1);
        chk("a_rd_c1_addr", bus.pmem_address, 16'h0040);
        chk("a_rd_c1_resp", {15'd0, bus.mem_resp_a}, 16'd0);
        step();
        chk("a_rd_c2", {15'd0, bus.pmem_read}, 16'd1);
        chk("a_rd_c2_addr", bus.pmem_address, 16'h0040);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h1234;
        step();
        chk("a_rd_resp", {15'd0, bus.mem_resp_a}, 16'd1);
        chk("a_rd_data", bus.mem_rdata_a, 16'h1234);
        chk_pmem_idle("a_rd_done");
        idle_inputs();
        step();
        chk("a_rd_rel", {15'd0, bus.mem_resp_a}, 16'd0);
        chk("a_rd_keep", bus.mem_rdata_a, 16'h1234);

        // Simultaneous a read / b write, b has priority
        bus.mem_read_a    = 1'b1;
        bus.mem_address_a = 16'h0010;
        bus.mem_write_b   = 1'b1;
        bus.mem_address_b = 16'h0200;
        bus.mem_wdata_b   = 16'hBEEF;
        bus.mem_wmask_b   = 2'b01;
        step();
        chk("sim_b_wr", {15'd0, bus.pmem_write}, 16'd1);
        chk("sim_b_rd", {15'd0, bus.pmem_read}, 16'd0);
        chk("sim_b_addr", bus.pmem_address, 16'h0200);
        chk("sim_b_wdata", bus.pmem_wdata, 16'hBEEF);
        chk("sim_b_wmask", {14'd0, bus.pmem_wmask}, 16'd1);
        bus.pmem_resp = 1'b1;
        step();
        chk("sim_b_resp", {15'd0, bus.mem_resp_b}, 16'd1);
        chk("sim_b_rdata", bus.mem_rdata_b, 16'h0000);
        chk_pmem_idle("sim_gap");
        bus.pmem_resp = 1'b0;
        step();
        chk("sim_a_rd", {15'd0, bus.pmem_read}, 16'd1);
        chk("sim_a_addr", bus.pmem_address, 16'h0010);
        chk("sim_b_resp2", {15'd0, bus.mem_resp_b}, HOLD);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h5A5A;
        step();
        chk("sim_a_resp", {15'd0, bus.mem_resp_a}, 16'd1);
        chk("sim_a_data", bus.mem_rdata_a, 16'h5A5A);
        chk("sim_b_resp3", {15'd0, bus.mem_resp_b}, HOLD);
        bus.pmem_resp = 1'b0;
        step();
        chk("sim_rel_a", {15'd0, bus.mem_resp_a}, 16'd0);
        chk("sim_rel_b", {15'd0, bus.mem_resp_b}, 16'd0);
        chk_pmem_idle("sim_rel");
        idle_inputs();
        step();

        // Held b after done_b: a must be served, not b again
        bus.mem_read_b    = 1'b1;
        bus.mem_address_b = 16'h0300;
        step();
        chk("hold_b_addr", bus.pmem_address, 16'h0300);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h1111;
        step();
        chk("hold_b_resp", {15'd0, bus.mem_resp_b}, 16'd1);
        bus.pmem_resp     = 1'b0;
        bus.mem_read_a    = 1'b1;
        bus.mem_address_a = 16'h0400;
        step();
        chk("hold_a_rd", {15'd0, bus.pmem_read}, 16'd1);
        chk("hold_a_addr", bus.pmem_address, 16'h0400);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h2222;
        step();
        chk("hold_a_data", bus.mem_rdata_a, 16'h2222);
        chk("hold_b_data", bus.mem_rdata_b, 16'h1111);
        chk("hold_a_resp", {15'd0, bus.mem_resp_a}, 16'd1);
        idle_inputs();
        step();
        chk_pmem_idle("hold_rel");

        // Reset pulse while BUSY_A
        bus.mem_read_a    = 1'b1;
        bus.mem_address_a = 16'h0500;
        step();
        chk("rb_busy", {15'd0, bus.pmem_read}, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rb_async_rd", {15'd0, bus.pmem_read}, 16'd0);
        chk("rb_async_addr", bus.pmem_address, 16'h0000);
        bus.mem_read_a = 1'b0;
        #1;
        reset_n       = 1'b1;
        bus.pmem_resp = 1'b1;
        step();
        chk("rb_no_resp", {15'd0, bus.mem_resp_a}, 16'd0);
        chk("rb_rdata", bus.mem_rdata_a, 16'h0000);
        chk_pmem_idle("rb_idle");
        bus.pmem_resp = 1'b0;
        step();
        chk("rb_no_resp2", {15'd0, bus.mem_resp_a}, 16'd0);

        // Port b read; response width
        bus.mem_read_b    = 1'b1;
        bus.mem_address_b = 16'h0100;
        step();
        chk("pb_addr", bus.pmem_address, 16'h0100);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'hCAFE;
        step();
        chk("pb_resp", {15'd0, bus.mem_resp_b}, 16'd1);
        chk("pb_data", bus.mem_rdata_b, 16'hCAFE);
        bus.pmem_resp = 1'b0;
        step();
        chk("pb_resp_off", {15'd0, bus.mem_resp_b}, 16'd0);
        bus.mem_read_b = 1'b0;
        step();
        chk("pb_resp_off2", {15'd0, bus.mem_resp_b}, 16'd0);
        chk_pmem_idle("pb_end");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
